// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: a 32-step restoring divider under FSM control.
// Remainder and quotient go out through one shared GR write port, and the PSW flags are strobed at DONE.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [REGW-1:0]  dest_q_i,
  input  logic [REGW-1:0]  dest_r_i,
  output logic             busy_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [REGW-1:0]  wb_addr_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic             psw_we_o,
  output logic             psw_ov_o,
  output logic             psw_s_o,
  output logic             psw_z_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ITER, S_FIX, S_WB_R, S_WB_Q, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend, shifted out as quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [REGW-1:0]  dest_q_q, dest_q_d;
  logic [REGW-1:0]  dest_r_q, dest_r_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             ovf_q, ovf_d;
  logic             ov_q, ov_d;
  logic             s_q, s_d;
  logic             z_q, z_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      dest_q_q <= '0;
      dest_r_q <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      ovf_q    <= 1'b0;
      ov_q     <= 1'b0;
      s_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      dest_q_q <= dest_q_d;
      dest_r_q <= dest_r_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      ovf_q    <= ovf_d;
      ov_q     <= ov_d;
      s_q      <= s_d;
      z_q      <= z_d;
    end
  end

  // One restoring step: the carry-out bit of the WIDTH+1-bit subtract is the borrow.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign quo_fix = sign_q_q ? -dvd_q : dvd_q;
  assign rem_fix = sign_r_q ? -rem_q : rem_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    dest_q_d   = dest_q_q;
    dest_r_d   = dest_r_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    ovf_d      = ovf_q;
    ov_d       = ov_q;
    s_d        = s_q;
    z_d        = z_q;
    wb_valid_o = 1'b0;
    wb_addr_o  = '0;
    wb_data_o  = '0;
    psw_we_o   = 1'b0;
    done_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d   = signed_i;
          dvd_d    = dividend_i;
          dvs_d    = divisor_i;
          dest_q_d = dest_q_i;
          dest_r_d = dest_r_i;
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        if (dvs_q == '0) begin
          ov_d    = 1'b1;
          s_d     = 1'b0;
          z_d     = 1'b0;
          state_d = S_DONE;
        end else begin
          ovf_d    = mode_q && (dvd_q == MIN_NEG) && (dvs_q == ALL_ONES);
          sign_q_d = mode_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          sign_r_d = mode_q && dvd_q[WIDTH-1];
          // The most negative value negates to itself, which is the right unsigned magnitude.
          if (mode_q && dvd_q[WIDTH-1]) dvd_d = -dvd_q;
          if (mode_q && dvs_q[WIDTH-1]) dvs_d = -dvs_q;
          rem_d    = '0;
          ov_d     = 1'b0;
          s_d      = 1'b0;
          z_d      = 1'b0;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (ovf_q) begin
          dvd_d = MIN_NEG;
          rem_d = '0;
          s_d   = 1'b1;
          z_d   = 1'b0;
        end else begin
          dvd_d = quo_fix;
          rem_d = rem_fix;
          s_d   = quo_fix[WIDTH-1];
          z_d   = (quo_fix == '0);
        end
        ov_d    = ovf_q;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        if (dest_r_q == '0) begin
          state_d = S_WB_Q;
        end else begin
          wb_valid_o = 1'b1;
          wb_addr_o  = dest_r_q;
          wb_data_o  = rem_q;
          if (wb_ready_i) state_d = S_WB_Q;
        end
      end
      S_WB_Q: begin
        if (dest_q_q == '0) begin
          state_d = S_DONE;
        end else begin
          wb_valid_o = 1'b1;
          wb_addr_o  = dest_q_q;
          wb_data_o  = dvd_q;
          if (wb_ready_i) state_d = S_DONE;
        end
      end
      S_DONE: begin
        psw_we_o = 1'b1;
        done_o   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o   = (state_q != S_IDLE);
  assign psw_ov_o = ov_q;
  assign psw_s_o  = s_q;
  assign psw_z_o  = z_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: cycle-exact writeback timing, results, flags, stalls and reset abort.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  dest_q_i = '0;
  logic [4:0]  dest_r_i = '0;
  logic        busy_o;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b1;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        psw_we_o;
  logic        psw_ov_o;
  logic        psw_s_o;
  logic        psw_z_o;
  logic        done_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          wr_total = 0;
  logic [4:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  int          wr_cyc  [256];

  div_sequencer #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .dest_q_i(dest_q_i), .dest_r_i(dest_r_i),
    .busy_o(busy_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .psw_we_o(psw_we_o),
    .psw_ov_o(psw_ov_o), .psw_s_o(psw_s_o), .psw_z_o(psw_z_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every completed GR write handshake with the interval it happened in.
  always @(negedge clk) begin
    if (wb_valid_o && wb_ready_i) begin
      wr_addr[wr_total % 256] = wb_addr_o;
      wr_data[wr_total % 256] = wb_data_o;
      wr_cyc[wr_total % 256]  = cyc;
      $display("WRITE cyc=%0d r%0d <= 0x%08h", cyc, wb_addr_o, wb_data_o);
      wr_total = wr_total + 1;
    end
  end

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, wb_valid_o, done_o, psw_we_o, psw_ov_o, psw_s_o, psw_z_o, wb_addr_o, wb_data_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b valid=%b done=%b we=%b ov=%b s=%b z=%b addr=%0d data=%h, expected all 0",
               busy_o, wb_valid_o, done_o, psw_we_o, psw_ov_o, psw_s_o, psw_z_o, wb_addr_o, wb_data_o);
    end
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b done=%b expected 0 0", busy_o, done_o);
    end
    $display("reset checked");
  endtask

  // Issue one divide and check every write, its cycle, completion cycle and flags.
  task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dq, input logic [4:0] dr,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic eov, input logic es, input logic ez, input int stall);
    int t0;
    int base;
    int done_at;
    int n_exp;
    int idx;
    bit found;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    base = wr_total;
    wb_ready_i = (stall == 0);
    @(posedge clk); #1;
    signed_i = s; dividend_i = a; divisor_i = b; dest_q_i = dq; dest_r_i = dr; start_i = 1'b1;
    t0 = cyc;
    @(posedge clk); #1 start_i = 1'b0;

    if (stall > 0) begin
      found = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (wb_valid_o) begin found = 1; break; end
      end
      checks++;
      if (!found || (cyc - t0) != 35) begin
        failures++;
        $display("FAIL %s stall_req_cycle: found=%0d cycle=%0d expected 35", name, found, cyc - t0);
      end
      hold_a = wb_addr_o;
      hold_d = wb_data_o;
      for (int i = 1; i < stall; i++) begin
        @(negedge clk);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_addr_o !== hold_a || wb_data_o !== hold_d || hold_a !== dr || hold_d !== er) begin
          failures++;
          $display("FAIL %s stall_stable: valid=%b addr=%0d data=%h expected 1 %0d %h",
                   name, wb_valid_o, wb_addr_o, wb_data_o, dr, er);
        end
      end
      @(posedge clk); #1 wb_ready_i = 1'b1;
    end

    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_o) begin found = 1; break; end
    end
    done_at = cyc - t0;
    checks++;
    if (!found || done_at != 37 + stall) begin
      failures++;
      $display("FAIL %s done_cycle: found=%0d cycle=%0d expected %0d", name, found, done_at, 37 + stall);
    end
    checks++;
    if (psw_we_o !== 1'b1 || psw_ov_o !== eov || psw_s_o !== es || psw_z_o !== ez) begin
      failures++;
      $display("FAIL %s flags: we=%b ov=%b s=%b z=%b expected 1 %b %b %b",
               name, psw_we_o, psw_ov_o, psw_s_o, psw_z_o, eov, es, ez);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || psw_ov_o !== eov || psw_s_o !== es || psw_z_o !== ez) begin
      failures++;
      $display("FAIL %s after_done: busy=%b done=%b ov=%b s=%b z=%b expected 0 0 %b %b %b",
               name, busy_o, done_o, psw_ov_o, psw_s_o, psw_z_o, eov, es, ez);
    end

    n_exp = ((dr != 0) ? 1 : 0) + ((dq != 0) ? 1 : 0);
    checks++;
    if (wr_total - base != n_exp) begin
      failures++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_total - base, n_exp);
    end else begin
      idx = base;
      if (dr != 0) begin
        checks++;
        if (wr_addr[idx % 256] !== dr || wr_data[idx % 256] !== er || wr_cyc[idx % 256] - t0 != 35 + stall) begin
          failures++;
          $display("FAIL %s rem_write: r%0d=%h at %0d expected r%0d=%h at %0d", name,
                   wr_addr[idx % 256], wr_data[idx % 256], wr_cyc[idx % 256] - t0, dr, er, 35 + stall);
        end
        idx++;
      end
      if (dq != 0) begin
        checks++;
        if (wr_addr[idx % 256] !== dq || wr_data[idx % 256] !== eq || wr_cyc[idx % 256] - t0 != 36 + stall) begin
          failures++;
          $display("FAIL %s quo_write: r%0d=%h at %0d expected r%0d=%h at %0d", name,
                   wr_addr[idx % 256], wr_data[idx % 256], wr_cyc[idx % 256] - t0, dq, eq, 36 + stall);
        end
      end
    end
    $display("%s: %0d/%0d done at +%0d ov=%b s=%b z=%b", name, a, b, done_at, psw_ov_o, psw_s_o, psw_z_o);
  endtask

  task automatic test_signed();
    run_div("s100_7", 1'b1, 32'd100, 32'd7, 5'd3, 5'd4, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 0);
    run_div("sneg100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 5'd3, 5'd4, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 0);
    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd6, 5'd7, 32'h80000000, 32'd0, 1'b1, 1'b1, 1'b0, 0);
    run_div("s7_neg100", 1'b1, 32'd7, 32'hFFFFFF9C, 5'd1, 5'd2, 32'd0, 32'd7, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_unsigned();
    run_div("u_max_2", 1'b0, 32'hFFFFFFFF, 32'd2, 5'd11, 5'd12, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_div_zero();
    int t0;
    int base;
    bit seen_done;
    base = wr_total;
    @(posedge clk); #1;
    signed_i = 1'b0; dividend_i = 32'd5; divisor_i = 32'd0; dest_q_i = 5'd9; dest_r_i = 5'd10; start_i = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    dividend_i = 32'd50; divisor_i = 32'd5;   // start held high while busy must be ignored
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL dz_busy: busy=%b expected 1", busy_o);
    end
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    checks++;
    if ((cyc - t0) != 2 || done_o !== 1'b1 || psw_we_o !== 1'b1 || psw_ov_o !== 1'b1 || psw_s_o !== 1'b0 || psw_z_o !== 1'b0) begin
      failures++;
      $display("FAIL dz_done: cycle=%0d done=%b we=%b ov=%b s=%b z=%b expected 2 1 1 1 0 0",
               cyc - t0, done_o, psw_we_o, psw_ov_o, psw_s_o, psw_z_o);
    end
    seen_done = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done_o || busy_o) seen_done = 1;
    end
    checks++;
    if (seen_done || wr_total != base || psw_ov_o !== 1'b1) begin
      failures++;
      $display("FAIL dz_idle: extra_activity=%0d writes=%0d ov=%b expected 0 0 1", seen_done, wr_total - base, psw_ov_o);
    end
    $display("div_zero: done at +2, ignored start while busy");
  endtask

  task automatic test_writeback();
    run_div("stall4", 1'b1, 32'd100, 32'd7, 5'd3, 5'd4, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 4);
    run_div("same_dest", 1'b0, 32'd20, 32'd6, 5'd5, 5'd5, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0, 0);
    run_div("dest_r0", 1'b0, 32'd9, 32'd4, 5'd8, 5'd0, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_abort();
    int t0;
    int base;
    bit seen;
    base = wr_total;
    @(posedge clk); #1;
    signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3; dest_q_i = 5'd1; dest_r_i = 5'd2; start_i = 1'b1;
    t0 = cyc;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || wb_valid_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: busy=%b valid=%b done=%b at +%0d expected 0 0 0", busy_o, wb_valid_o, done_o, cyc - t0);
    end
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done_o || busy_o) seen = 1;
    end
    checks++;
    if (seen || wr_total != base) begin
      failures++;
      $display("FAIL abort_quiet: activity=%0d writes=%0d expected 0 0", seen, wr_total - base);
    end
    $display("reset_abort: aborted at +11");
    run_div("after_abort", 1'b0, 32'd1000, 32'd3, 5'd1, 5'd2, 32'd333, 32'd1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_writeback();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle sequencer for the DIV/DIVU datapath path of the execute stage.
- Replaces the single-cycle divide in the execute unit with a 32-iteration restoring divider under FSM control.
- Writes quotient and remainder through one shared GR write port via a valid/ready handshake.
- Produces PSW OV/S/Z updates; the issue logic holds the pipeline while busy_o=1.

Parameters:
- WIDTH, 32, operand/result width in bits.
- REGW, 5, general-register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  request a divide; accepted only when busy_o=0.
- signed_i  in  1  1=DIV (signed), 0=DIVU (unsigned); sampled at start.
- dividend_i  in  WIDTH  reg2 value; sampled at start.
- divisor_i  in  WIDTH  reg1 value; sampled at start.
- dest_q_i  in  REGW  quotient destination register number; sampled at start.
- dest_r_i  in  REGW  remainder destination register number (reg3); sampled at start.
- busy_o  out  1  high from the cycle after accept until return to IDLE.
- wb_valid_o  out  1  GR write request.
- wb_ready_i  in  1  GR write port grant.
- wb_addr_o  out  REGW  GR write address.
- wb_data_o  out  WIDTH  GR write data.
- psw_we_o  out  1  one-cycle PSW flag write strobe.
- psw_ov_o  out  1  overflow flag value.
- psw_s_o  out  1  sign flag value (quotient[WIDTH-1]).
- psw_z_o  out  1  zero flag value (quotient==0).
- done_o  out  1  one-cycle completion pulse, coincident with psw_we_o.

Behaviour:
- Reset: state=IDLE, iteration counter=0; all outputs 0. Reset asserted in any state aborts the operation: no further writeback, no done_o.
- States: IDLE, PREP, ITER, FIX, WB_R, WB_Q, DONE.
- IDLE: start_i=1 latches operands, mode and destinations, then goes to PREP. start_i is ignored in every other state.
- PREP (1 cycle):
  - Divisor==0: OV=1, S=0, Z=0; go to DONE with no GR writes.
  - Signed mode: latch sign_q = dividend sign XOR divisor sign and sign_r = dividend sign, then take absolute values (0x80000000 stays 0x80000000, treated as unsigned 2^31).
  - Otherwise go to ITER with counter=WIDTH-1.
- ITER (WIDTH cycles):
  - One restoring step per cycle: shift the partial remainder left and bring in the next dividend bit (MSB first).
  - Subtract the divisor on a WIDTH+1-bit adder; if non-negative, keep the difference and set quotient bit=1.
  - Counter decrements each cycle; go to FIX when it reaches 0.
- FIX (1 cycle):
  - Negate the quotient if sign_q; negate the remainder if sign_r, so the remainder sign follows the dividend.
  - OV=1 only for signed 0x80000000 / 0xFFFFFFFF; that case yields quotient 0x80000000, remainder 0.
  - S=quotient[WIDTH-1]; Z=(quotient==0).
- WB_R:
  - wb_valid_o=1, wb_addr_o=dest_r, wb_data_o=remainder; advance to WB_Q on wb_valid_o & wb_ready_i.
  - wb_addr_o and wb_data_o stay stable while waiting for ready.
  - dest_r==0: skip directly to WB_Q, no request.
- WB_Q: same handshake with dest_q and the quotient; advance to DONE. dest_q==0: skip.
- Same register for both destinations (dest_q==dest_r): both writes are issued, and the quotient is written last, so the quotient wins.
- DONE (1 cycle): done_o=1, psw_we_o=1, flag outputs valid; next state IDLE.
- Flag outputs hold their value until the next PREP.
- busy_o=0 only in IDLE.
- Latency with wb_ready_i tied 1: accept in cycle 0 gives WB_R in cycle 35, WB_Q in 36, DONE in 37, IDLE in 38.
- Divide-by-zero latency: accept in cycle 0 gives DONE in cycle 2.
- wb_valid_o never asserts in IDLE, PREP, ITER, FIX or DONE.

Test Plan:
- Signed 100/7, dest_q=3, dest_r=4, ready=1 -> cycle 35 writes r4=2; cycle 36 writes r3=14; cycle 37 done with OV=0, S=0, Z=0.
- Signed 0xFFFFFF9C(-100)/7 -> remainder 0xFFFFFFFE, quotient 0xFFFFFFF2; S=1, Z=0, OV=0.
- Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; OV=1, S=1, Z=0.
- Unsigned 0xFFFFFFFF/2 -> quotient 0x7FFFFFFF, remainder 1, S=0. Then 5/0 -> no wb_valid_o, done in cycle 2 with OV=1; start_i pulsed while busy is ignored.
- wb_ready_i held 0 for 4 cycles in WB_R -> addr/data stable; DONE is delayed by exactly 4 cycles. dest_q=dest_r=5 -> last write to r5 is the quotient. dest_r=0 -> only one write.
- rst_i asserted at cycle 10 of ITER -> next cycle IDLE, busy_o=0, no writes, no done. A new start afterwards completes correctly.
